// File: rtl/draw_crosshair_multi_pkg.sv
// -----------------------------------------------------------------------------
// draw_crosshair_multi_pkg
// Shared constants and types for the multi-player crosshair overlay stage.
//   CROSSHAIR_DEFAULT_COLOUR : colour used for a crosshair when none is supplied
//   CROSSHAIR_FLASH_COLOUR   : colour shown while a channel's shot flash runs
//   flash_state_t            : per-channel shot flash state (IDLE/ARMED/FLASH)
//   coord_dist()             : |a - b| of two 12-bit screen coordinates
// -----------------------------------------------------------------------------
package draw_crosshair_multi_pkg;

   localparam int unsigned COORD_W = 12;
   localparam int unsigned RGB_W   = 12;
   localparam int unsigned CNT_W   = 8;

   localparam logic [RGB_W-1:0] CROSSHAIR_DEFAULT_COLOUR = 12'hf_0_0;
   localparam logic [RGB_W-1:0] CROSSHAIR_FLASH_COLOUR   = 12'hf_f_f;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      FLASH = 2'd2
   } flash_state_t;

   // Distance between two coordinates in 13-bit signed arithmetic, so a
   // crosshair near x = 0 never "wraps" onto pixels near hcount = 4095.
   function automatic logic [COORD_W-1:0] coord_dist(
      input logic [COORD_W-1:0] a,
      input logic [COORD_W-1:0] b
   );
      logic signed [COORD_W:0] d;
      logic signed [COORD_W:0] n;
      d = $signed({1'b0, a}) - $signed({1'b0, b});
      n = -d;
      if (d[COORD_W]) begin
         coord_dist = n[COORD_W-1:0];
      end else begin
         coord_dist = d[COORD_W-1:0];
      end
   endfunction

endpackage

// File: rtl/draw_crosshair_multi_if.sv
// -----------------------------------------------------------------------------
// draw_crosshair_multi_if
// VGA timing + pixel bus passed between draw stages.
//   vcount/hcount : current pixel coordinates
//   vsync/hsync   : sync pulses
//   vblnk/hblnk   : blanking flags
//   rgb           : 12-bit pixel colour
// Modports:
//   in  : consumer side (stage reading the bus)
//   out : producer side (stage driving the bus)
// -----------------------------------------------------------------------------
interface draw_crosshair_multi_if;

   logic [11:0] vcount;
   logic        vsync;
   logic        vblnk;
   logic [11:0] hcount;
   logic        hsync;
   logic        hblnk;
   logic [11:0] rgb;

   modport in (
      input vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
   );

   modport out (
      output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb
   );

endinterface

// File: rtl/draw_crosshair_multi_channel.sv
// -----------------------------------------------------------------------------
// draw_crosshair_multi_channel
// One crosshair channel: frame latch of position/enable, shot flash FSM and
// the combinational hit test against the current pixel.
// Ports:
//   clk, rst          : pixel clock, async active-high reset
//   i_fs              : single-cycle frame start
//   i_xpos, i_ypos    : live crosshair centre (latched on i_fs)
//   i_enable          : live draw enable (latched on i_fs)
//   i_trig            : single-cycle shot pulse
//   i_hcount,i_vcount : pixel under test
//   o_hit             : pixel lies on an enabled crosshair of this channel
//   o_flash           : channel is showing its flash colour this frame
// -----------------------------------------------------------------------------
module draw_crosshair_multi_channel
   import draw_crosshair_multi_pkg::*;
#(
   parameter int ARM_LEN      = 20,
   parameter int THICK        = 1,
   parameter int FLASH_FRAMES = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_fs,
   input  logic [COORD_W-1:0] i_xpos,
   input  logic [COORD_W-1:0] i_ypos,
   input  logic               i_enable,
   input  logic               i_trig,
   input  logic [COORD_W-1:0] i_hcount,
   input  logic [COORD_W-1:0] i_vcount,
   output logic               o_hit,
   output logic               o_flash
);

   localparam int               HALF_W   = (THICK - 1) / 2;
   localparam logic [COORD_W-1:0] ARM_LIM  = COORD_W'(ARM_LEN);
   localparam logic [COORD_W-1:0] HALF_LIM = COORD_W'(HALF_W);
   localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(FLASH_FRAMES);

   logic [COORD_W-1:0] r_xpos;
   logic [COORD_W-1:0] r_ypos;
   logic               r_enable;
   flash_state_t       r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_pending;

   logic [COORD_W-1:0] w_dx;
   logic [COORD_W-1:0] w_dy;
   logic               w_harm;
   logic               w_varm;

   // Frame latch: drawing only ever sees positions captured at frame start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_xpos   <= 12'd0;
         r_ypos   <= 12'd0;
         r_enable <= 1'b0;
      end else if (i_fs) begin
         r_xpos   <= i_xpos;
         r_ypos   <= i_ypos;
         r_enable <= i_enable;
      end
   end

   // Shot flash FSM. A trig arriving on an fs cycle belongs to the frame that
   // fs opens, so it is held as pending and restarts the flash one fs later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 8'd0;
         r_pending <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_pending <= 1'b0;
               if (i_trig) begin
                  r_state <= ARMED;
               end
            end
            ARMED: begin
               if (i_fs) begin
                  r_state   <= FLASH;
                  r_cnt     <= CNT_LOAD;
                  r_pending <= i_trig;
               end
            end
            FLASH: begin
               if (i_fs) begin
                  r_pending <= i_trig;
                  if (r_pending) begin
                     r_cnt <= CNT_LOAD;
                  end else if (r_cnt == 8'd1) begin
                     r_cnt     <= 8'd0;
                     r_pending <= 1'b0;
                     // A trig on the final fs re-arms instead of being dropped.
                     r_state   <= i_trig ? ARMED : IDLE;
                  end else begin
                     r_cnt <= r_cnt - 8'd1;
                  end
               end else if (i_trig) begin
                  r_pending <= 1'b1;
               end
            end
            default: begin
               r_state   <= IDLE;
               r_cnt     <= 8'd0;
               r_pending <= 1'b0;
            end
         endcase
      end
   end

   // Hit test: plus-shaped region made of two thick arms around the centre.
   always_comb begin
      w_dx   = coord_dist(i_hcount, r_xpos);
      w_dy   = coord_dist(i_vcount, r_ypos);
      w_harm = (w_dx <= ARM_LIM) && (w_dy <= HALF_LIM);
      w_varm = (w_dy <= ARM_LIM) && (w_dx <= HALF_LIM);
   end

   assign o_hit   = r_enable & (w_harm | w_varm);
   assign o_flash = (r_state == FLASH);

endmodule

// File: rtl/draw_crosshair_multi.sv
// -----------------------------------------------------------------------------
// draw_crosshair_multi
// Overlays up to N_CH crosshairs onto the VGA stream with one clock latency.
// Ports:
//   clk, rst : pixel clock, async active-high reset
//   xpos     : N_CH x 12 crosshair centre x
//   ypos     : N_CH x 12 crosshair centre y
//   enable   : N_CH draw enables
//   colour   : N_CH x 12 normal crosshair colours
//   trig     : N_CH single-cycle shot pulses
//   in       : incoming VGA bus
//   out      : VGA bus delayed by one register stage, rgb overlaid
// -----------------------------------------------------------------------------
module draw_crosshair_multi
   import draw_crosshair_multi_pkg::*;
#(
   parameter int N_CH         = 2,
   parameter int ARM_LEN      = 20,
   parameter int THICK        = 1,
   parameter int FLASH_FRAMES = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_CH-1:0][COORD_W-1:0]  xpos,
   input  logic [N_CH-1:0][COORD_W-1:0]  ypos,
   input  logic [N_CH-1:0]               enable,
   input  logic [N_CH-1:0][RGB_W-1:0]    colour,
   input  logic [N_CH-1:0]               trig,
   draw_crosshair_multi_if.in            in,
   draw_crosshair_multi_if.out           out
);

   logic               r_vsync_q;
   logic               w_fs;
   logic [N_CH-1:0]    w_hit;
   logic [N_CH-1:0]    w_flash;
   logic               w_active;
   logic               w_found;
   logic [RGB_W-1:0]   w_pix;

   // Registered vsync copy used to find the rising edge (frame start).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vsync_q <= 1'b0;
      end else begin
         r_vsync_q <= in.vsync;
      end
   end

   assign w_fs = in.vsync & ~r_vsync_q;

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      draw_crosshair_multi_channel #(
         .ARM_LEN      (ARM_LEN),
         .THICK        (THICK),
         .FLASH_FRAMES (FLASH_FRAMES)
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .i_fs     (w_fs),
         .i_xpos   (xpos[g]),
         .i_ypos   (ypos[g]),
         .i_enable (enable[g]),
         .i_trig   (trig[g]),
         .i_hcount (in.hcount),
         .i_vcount (in.vcount),
         .o_hit    (w_hit[g]),
         .o_flash  (w_flash[g])
      );
   end

   // Priority mux: lowest-index hitting channel wins; blanking passes rgb.
   always_comb begin
      w_active = ~(in.hblnk | in.vblnk);
      w_found  = 1'b0;
      w_pix    = in.rgb;
      for (int i = 0; i < N_CH; i++) begin
         if (w_active && !w_found && w_hit[i]) begin
            w_found = 1'b1;
            if (w_flash[i]) begin
               w_pix = CROSSHAIR_FLASH_COLOUR;
            end else begin
               w_pix = colour[i];
            end
         end else begin
            w_found = w_found;
         end
      end
   end

   // Output register: every bus field is delayed by exactly one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out.vcount <= 12'd0;
         out.vsync  <= 1'b0;
         out.vblnk  <= 1'b0;
         out.hcount <= 12'd0;
         out.hsync  <= 1'b0;
         out.hblnk  <= 1'b0;
         out.rgb    <= 12'd0;
      end else begin
         out.vcount <= in.vcount;
         out.vsync  <= in.vsync;
         out.vblnk  <= in.vblnk;
         out.hcount <= in.hcount;
         out.hsync  <= in.hsync;
         out.hblnk  <= in.hblnk;
         out.rgb    <= w_pix;
      end
   end

endmodule

// File: tb/tb_draw_crosshair_multi.sv
// -----------------------------------------------------------------------------
// tb_draw_crosshair_multi
// Self-checking bench: table of fixed pixel probes, hand-written frame
// sequences for latching and flash timing, then randomized traffic compared
// against a frame-level behavioural model.
// -----------------------------------------------------------------------------
module tb_draw_crosshair_multi;

   localparam int NC  = 2;
   localparam int ARM = 20;
   localparam int THK = 3;
   localparam int FF  = 3;
   localparam int HWD = (THK - 1) / 2;

   localparam logic [11:0] BG = 12'h123;
   localparam logic [11:0] C0 = 12'h0f0;
   localparam logic [11:0] C1 = 12'h00f;
   localparam logic [11:0] WH = 12'hfff;

   typedef struct packed {
      logic [11:0] vc;
      logic        vs;
      logic        vb;
      logic [11:0] hc;
      logic        hs;
      logic        hb;
      logic [11:0] rgb;
   } vga_t;

   typedef struct {
      logic [11:0] h;
      logic [11:0] v;
      logic [11:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NC-1:0][11:0] xpos;
   logic [NC-1:0][11:0] ypos;
   logic [NC-1:0][11:0] colour;
   logic [NC-1:0]       enable;
   logic [NC-1:0]       trig;

   int n_vec = 0;
   int n_err = 0;

   // Behavioural model: frame number, per-channel latched frame data and the
   // frame index of the latest shot known before the current frame began.
   logic [11:0] m_x    [NC];
   logic [11:0] m_y    [NC];
   logic        m_en   [NC];
   int          m_last [NC];
   int          m_snap [NC];
   int          m_frame;
   logic        m_vq;

   draw_crosshair_multi_if vga_in ();
   draw_crosshair_multi_if vga_out ();

   draw_crosshair_multi #(
      .N_CH         (NC),
      .ARM_LEN      (ARM),
      .THICK        (THK),
      .FLASH_FRAMES (FF)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .xpos   (xpos),
      .ypos   (ypos),
      .enable (enable),
      .colour (colour),
      .trig   (trig),
      .in     (vga_in),
      .out    (vga_out)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int i = 0; i < NC; i++) begin
         m_x[i]    = 12'd0;
         m_y[i]    = 12'd0;
         m_en[i]   = 1'b0;
         m_last[i] = -100;
         m_snap[i] = -100;
      end
      m_frame = 0;
      m_vq    = 1'b0;
   endtask

   // A channel flashes in frame f when some shot landed in one of frames
   // f-FF .. f-1; with same-length windows only the latest shot matters.
   function automatic logic [11:0] model_pix(input logic [11:0] h, input logic [11:0] v,
                                             input logic hb, input logic vb,
                                             input logic [11:0] rgb);
      int dx;
      int dy;
      int age;
      if (hb || vb) return rgb;
      for (int i = 0; i < NC; i++) begin
         dx = int'(h) - int'(m_x[i]);
         dy = int'(v) - int'(m_y[i]);
         if (dx < 0) dx = -dx;
         if (dy < 0) dy = -dy;
         if (m_en[i] && ((dx <= ARM && dy <= HWD) || (dy <= ARM && dx <= HWD))) begin
            age = m_frame - m_snap[i];
            return (age >= 1 && age <= FF) ? WH : colour[i];
         end
      end
      return rgb;
   endfunction

   task automatic check_zero(input string nm);
      vga_t got;
      got = {vga_out.vcount, vga_out.vsync, vga_out.vblnk, vga_out.hcount,
             vga_out.hsync, vga_out.hblnk, vga_out.rgb};
      n_vec++;
      if (got !== '0) begin
         n_err++;
         $display("FAIL %s got=%h exp=0", nm, got);
      end
   endtask

   // One pixel clock: apply inputs, predict, clock, compare all out fields.
   task automatic drive(input logic [11:0] h, input logic [11:0] v, input logic vs,
                        input logic hs, input logic hb, input logic vb,
                        input logic [11:0] rgb, output logic [11:0] act);
      vga_t exp;
      vga_t got;
      vga_in.hcount = h;
      vga_in.vcount = v;
      vga_in.vsync  = vs;
      vga_in.hsync  = hs;
      vga_in.hblnk  = hb;
      vga_in.vblnk  = vb;
      vga_in.rgb    = rgb;
      exp = {v, vs, vb, h, hs, hb, model_pix(h, v, hb, vb, rgb)};
      @(posedge clk);
      #1;
      got = {vga_out.vcount, vga_out.vsync, vga_out.vblnk, vga_out.hcount,
             vga_out.hsync, vga_out.hblnk, vga_out.rgb};
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL pipe_model h=%0d v=%0d got=%h exp=%h", h, v, got, exp);
      end
      act = vga_out.rgb;
      if (vs && !m_vq) begin
         for (int i = 0; i < NC; i++) begin
            m_x[i]    = xpos[i];
            m_y[i]    = ypos[i];
            m_en[i]   = enable[i];
            m_snap[i] = m_last[i];
         end
         m_frame++;
      end
      m_vq = vs;
      for (int i = 0; i < NC; i++) begin
         if (trig[i]) m_last[i] = m_frame;
      end
   endtask

   task automatic probe(input logic [11:0] h, input logic [11:0] v, input logic hb,
                        input logic vb, input logic [11:0] exp, input string nm);
      logic [11:0] act;
      drive(h, v, 1'b0, 1'b0, hb, vb, BG, act);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s h=%0d v=%0d got=%h exp=%h", nm, h, v, act, exp);
      end
   endtask

   task automatic do_fs();
      logic [11:0] act;
      drive(12'd0, 12'd490, 1'b1, 1'b0, 1'b1, 1'b1, BG, act);
      drive(12'd0, 12'd491, 1'b0, 1'b0, 1'b1, 1'b1, BG, act);
   endtask

   vec_t tbl [14];

   initial begin
      logic [11:0] act;
      logic [11:0] h;
      logic [11:0] v;
      int          c;

      tbl[0]  = '{12'd100, 12'd80,  C0};
      tbl[1]  = '{12'd120, 12'd100, C0};
      tbl[2]  = '{12'd121, 12'd100, BG};
      tbl[3]  = '{12'd80,  12'd100, C0};
      tbl[4]  = '{12'd79,  12'd100, BG};
      tbl[5]  = '{12'd100, 12'd120, C0};
      tbl[6]  = '{12'd100, 12'd121, BG};
      tbl[7]  = '{12'd101, 12'd80,  C0};
      tbl[8]  = '{12'd102, 12'd80,  BG};
      tbl[9]  = '{12'd99,  12'd119, C0};
      tbl[10] = '{12'd121, 12'd101, BG};
      tbl[11] = '{12'd110, 12'd101, C0};
      tbl[12] = '{12'd110, 12'd102, BG};
      tbl[13] = '{12'd100, 12'd100, C0};

      xpos   = '0;
      ypos   = '0;
      colour = '0;
      enable = '0;
      trig   = '0;
      vga_in.hcount = 12'd0;
      vga_in.vcount = 12'd0;
      vga_in.vsync  = 1'b0;
      vga_in.hsync  = 1'b0;
      vga_in.hblnk  = 1'b0;
      vga_in.vblnk  = 1'b0;
      vga_in.rgb    = 12'd0;
      model_reset();

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_state");
      rst = 1'b0;

      // ch0 at (100,100): invisible until the first fs, then the table.
      xpos[0] = 12'd100; ypos[0] = 12'd100; enable = 2'b01; colour[0] = C0;
      colour[1] = C1;
      probe(12'd100, 12'd100, 1'b0, 1'b0, BG, "before_first_fs");
      do_fs();
      for (int i = 0; i < 14; i++) begin
         probe(tbl[i].h, tbl[i].v, 1'b0, 1'b0, tbl[i].exp, $sformatf("table_%0d", i));
      end

      // Asynchronous reset mid-frame clears outputs and frame registers.
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      probe(12'd100, 12'd100, 1'b0, 1'b0, BG, "after_reset_no_fs");
      do_fs();
      probe(12'd100, 12'd100, 1'b0, 1'b0, C0, "after_reset_fs");

      // Mid-frame move takes effect only after the next fs.
      xpos[0] = 12'd300;
      probe(12'd100, 12'd100, 1'b0, 1'b0, C0, "move_old_frame");
      probe(12'd300, 12'd100, 1'b0, 1'b0, BG, "move_new_hidden");
      do_fs();
      probe(12'd300, 12'd100, 1'b0, 1'b0, C0, "move_new_frame");
      probe(12'd100, 12'd100, 1'b0, 1'b0, BG, "move_old_gone");

      // Screen-edge crosshair with no wrap.
      xpos[0] = 12'd5; ypos[0] = 12'd5;
      do_fs();
      probe(12'd0,    12'd4,    1'b0, 1'b0, C0, "edge_0_4");
      probe(12'd0,    12'd6,    1'b0, 1'b0, C0, "edge_0_6");
      probe(12'd25,   12'd5,    1'b0, 1'b0, C0, "edge_25_5");
      probe(12'd26,   12'd5,    1'b0, 1'b0, BG, "edge_26_5");
      probe(12'd4095, 12'd5,    1'b0, 1'b0, BG, "nowrap_h");
      probe(12'd5,    12'd4095, 1'b0, 1'b0, BG, "nowrap_v");
      probe(12'd0,    12'd0,    1'b0, 1'b0, BG, "edge_corner");

      // Overlap priority.
      xpos = {12'd200, 12'd200}; ypos = {12'd200, 12'd200}; enable = 2'b11;
      do_fs();
      probe(12'd200, 12'd200, 1'b0, 1'b0, C0, "overlap_ch0");
      enable = 2'b10;
      probe(12'd200, 12'd200, 1'b0, 1'b0, C0, "overlap_en_midframe");
      do_fs();
      probe(12'd200, 12'd200, 1'b0, 1'b0, C1, "overlap_ch1");

      // Flash: one shot gives frames 1..3; a second shot in frame 2 extends.
      xpos[1] = 12'd400; ypos[1] = 12'd300;
      do_fs();
      probe(12'd400, 12'd300, 1'b0, 1'b0, C1, "flash_pre");
      trig = 2'b10;
      probe(12'd400, 12'd300, 1'b0, 1'b0, C1, "flash_trig_frame");
      trig = 2'b00;
      for (int k = 1; k <= 5; k++) begin
         do_fs();
         probe(12'd400, 12'd300, 1'b0, 1'b0, (k <= 3) ? WH : C1, $sformatf("flash_a_f%0d", k));
      end
      trig = 2'b10;
      probe(12'd400, 12'd300, 1'b0, 1'b0, C1, "flash_b_trig");
      trig = 2'b00;
      for (int k = 1; k <= 6; k++) begin
         do_fs();
         if (k == 2) trig = 2'b10;
         probe(12'd400, 12'd300, 1'b0, 1'b0, (k <= 5) ? WH : C1, $sformatf("flash_b_f%0d", k));
         trig = 2'b00;
      end

      // Blanking passes in.rgb even on the crosshair.
      xpos[1] = 12'd630; ypos[1] = 12'd100;
      do_fs();
      probe(12'd640, 12'd100, 1'b1, 1'b0, BG, "hblnk_pass");
      probe(12'd640, 12'd100, 1'b0, 1'b1, BG, "vblnk_pass");
      probe(12'd640, 12'd100, 1'b0, 1'b0, C1, "active_640");

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            #2;
            rst = 1'b1;
            #1;
            check_zero("random_reset");
            @(posedge clk);
            #1;
            rst = 1'b0;
            model_reset();
         end
         if ($urandom_range(0, 49) == 0) begin
            c = $urandom_range(0, NC - 1);
            xpos[c]   = 12'($urandom_range(0, 700));
            ypos[c]   = 12'($urandom_range(0, 500));
            colour[c] = 12'($urandom);
            enable    = 2'($urandom);
         end
         trig = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         c = $urandom_range(0, NC - 1);
         if ($urandom_range(0, 7) == 0) begin
            h = 12'($urandom);
            v = 12'($urandom);
         end else begin
            h = xpos[c] + 12'($urandom_range(0, 50)) - 12'd25;
            v = ypos[c] + 12'($urandom_range(0, 50)) - 12'd25;
         end
         drive(h, v, ((n % 200) < 3) ? 1'b1 : 1'b0, 1'($urandom),
               ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
               ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0,
               12'($urandom), act);
      end
      trig = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
